apb_req_arbiter: RTL and testbench

//  Shares one APB bridge port among NUM_REQ local requesters using round-robin arbitration.

---
 rtl/apb_req_arbiter_if.sv | 44 ++++
 rtl/apb_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_apb_req_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-side signal bundle for apb_req_arbiter.
// master = arbiter view, slave = requesters plus APB bridge view.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb;
  logic [NUM_REQ*3-1:0]          req_prot;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            done;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;

  logic [ADDR_WIDTH-1:0]         paddr;
  logic                          psel;
  logic                          penable;
  logic                          pwrite;
  logic [DATA_WIDTH-1:0]         pwdata;
  logic [STRB_WIDTH-1:0]         pstrb;
  logic [2:0]                    pprot;
  logic [DATA_WIDTH-1:0]         prdata;
  logic                          pready;
  logic                          pslverr;

  modport master (
    input  req, req_write, req_addr, req_wdata, req_strb, req_prot,
    output grant, done, rsp_rdata, rsp_err,
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  grant, done, rsp_rdata, rsp_err,
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to end an ACCESS phase stuck without pready after TIMEOUT cycles.
module apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  apb_req_arbiter_if.master bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;
  state_t r_state, w_state_nxt;

  logic [PW-1:0]         r_ptr, w_ptr_nxt, r_owner, w_owner_nxt, w_win;
  logic                  w_found, w_tmo;
  logic [NUM_REQ-1:0]    w_req_m;
  logic                  r_psel, w_psel, r_penable, w_penable, r_pwrite, w_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata, r_rdata, w_rdata;
  logic [STRB_WIDTH-1:0] r_pstrb, w_pstrb;
  logic [2:0]            r_pprot, w_pprot;
  logic [NUM_REQ-1:0]    r_grant, w_grant, r_done, w_done;
  logic                  r_err, w_err;

  // The owner's req is still high in its done cycle; mask it so it is not re-granted.
  always_comb begin
    w_req_m = bus.req & ~r_done;
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [PW:0] sum;
      sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      if (!w_found && w_req_m[sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = sum[PW-1:0];
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state == S_SETUP)                          w_cnt_nxt = '0;
    else if (r_state == S_ACCESS && !bus.pready)     w_cnt_nxt = r_cnt + 1'b1;
  end

  assign w_tmo = (r_state == S_ACCESS) && !bus.pready && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_cnt <= '0;
    else          r_cnt <= w_cnt_nxt;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_pwrite    = r_pwrite;
    w_paddr     = r_paddr;
    w_pwdata    = r_pwdata;
    w_pstrb     = r_pstrb;
    w_pprot     = r_pprot;
    w_grant     = r_grant;
    w_done      = '0;
    w_rdata     = '0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: if (w_found) begin
        w_state_nxt = S_SETUP;
        w_owner_nxt = w_win;
        w_grant     = NUM_REQ'(1) << w_win;
        w_psel      = 1'b1;
        w_penable   = 1'b0;
        w_pwrite    = bus.req_write[w_win];
        w_paddr     = bus.req_addr [w_win*ADDR_WIDTH +: ADDR_WIDTH];
        w_pwdata    = bus.req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
        w_pstrb     = bus.req_strb [w_win*STRB_WIDTH +: STRB_WIDTH];
        w_pprot     = bus.req_prot [w_win*3 +: 3];
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
        w_penable   = 1'b1;
      end
      S_ACCESS: if (bus.pready || w_tmo) begin
        w_state_nxt = S_IDLE;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_grant     = '0;
        w_done      = r_grant;
        w_err       = bus.pready ? bus.pslverr : 1'b1;
        w_rdata     = (bus.pready && !r_pwrite) ? bus.prdata : '0;
        w_ptr_nxt   = (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_pprot   <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_psel    <= w_psel;
      r_penable <= w_penable;
      r_pwrite  <= w_pwrite;
      r_paddr   <= w_paddr;
      r_pwdata  <= w_pwdata;
      r_pstrb   <= w_pstrb;
      r_pprot   <= w_pprot;
      r_grant   <= w_grant;
      r_done    <= w_done;
      r_rdata   <= w_rdata;
      r_err     <= w_err;
    end
  end

  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.pstrb     = r_pstrb;
  assign bus.pprot     = r_pprot;
  assign bus.grant     = r_grant;
  assign bus.done      = r_done;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: single read, round-robin order, wait states with
// pslverr, mid-transfer reset, and ACCESS timeout (or its absence).
module tb_apb_req_arbiter;
  logic pclk;
  logic presetn;
  int   checks = 0;
  int   errors = 0;

  apb_req_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) bus ();

  apb_req_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT(16)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic test_reset();
    presetn = 1'b0;
    bus.req = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_strb = '0; bus.req_prot = '0;
    bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    checks++; if (bus.psel !== 1'b0)      begin errors++; $display("FAIL reset_psel got %0h exp 0", bus.psel); end
    checks++; if (bus.penable !== 1'b0)   begin errors++; $display("FAIL reset_penable got %0h exp 0", bus.penable); end
    checks++; if (bus.grant !== 4'h0)     begin errors++; $display("FAIL reset_grant got %0h exp 0", bus.grant); end
    checks++; if (bus.done !== 4'h0)      begin errors++; $display("FAIL reset_done got %0h exp 0", bus.done); end
    checks++; if (bus.rsp_rdata !== '0)   begin errors++; $display("FAIL reset_rdata got %0h exp 0", bus.rsp_rdata); end
    checks++; if (bus.rsp_err !== 1'b0)   begin errors++; $display("FAIL reset_err got %0h exp 0", bus.rsp_err); end
    checks++; if (bus.paddr !== '0)       begin errors++; $display("FAIL reset_paddr got %0h exp 0", bus.paddr); end
    presetn = 1'b1;
  endtask

  task automatic test_single_read();
    bus.req_addr[0 +: 32] = 32'h10;
    bus.req_write[0] = 1'b0;
    bus.pready = 1'b1;
    bus.prdata = 32'hA5A5_0001;
    bus.req = 4'b0001;
    @(negedge pclk);
    checks++; if (bus.psel !== 1'b1)      begin errors++; $display("FAIL t1_setup_psel got %0h exp 1", bus.psel); end
    checks++; if (bus.penable !== 1'b0)   begin errors++; $display("FAIL t1_setup_penable got %0h exp 0", bus.penable); end
    checks++; if (bus.grant !== 4'b0001)  begin errors++; $display("FAIL t1_grant got %0h exp 1", bus.grant); end
    checks++; if (bus.paddr !== 32'h10)   begin errors++; $display("FAIL t1_paddr got %0h exp 10", bus.paddr); end
    @(negedge pclk);
    checks++; if (bus.penable !== 1'b1)   begin errors++; $display("FAIL t1_access_penable got %0h exp 1", bus.penable); end
    checks++; if (bus.done !== 4'b0000)   begin errors++; $display("FAIL t1_early_done got %0h exp 0", bus.done); end
    @(negedge pclk);
    checks++; if (bus.done !== 4'b0001)   begin errors++; $display("FAIL t1_done got %0h exp 1", bus.done); end
    checks++; if (bus.rsp_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL t1_rdata got %0h exp a5a50001", bus.rsp_rdata); end
    checks++; if (bus.rsp_err !== 1'b0)   begin errors++; $display("FAIL t1_err got %0h exp 0", bus.rsp_err); end
    checks++; if (bus.psel !== 1'b0)      begin errors++; $display("FAIL t1_done_psel got %0h exp 0", bus.psel); end
    bus.req = 4'b0000;
    @(negedge pclk);
    checks++; if (bus.done !== 4'b0000)   begin errors++; $display("FAIL t1_done_clear got %0h exp 0", bus.done); end
    checks++; if (bus.rsp_rdata !== '0)   begin errors++; $display("FAIL t1_rdata_clear got %0h exp 0", bus.rsp_rdata); end
    checks++; if (bus.paddr !== 32'h10)   begin errors++; $display("FAIL t1_paddr_hold got %0h exp 10", bus.paddr); end
  endtask

  task automatic test_round_robin();
    presetn = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 4; i++) bus.req_addr[i*32 +: 32] = 32'h100 + 32'(i*4);
    bus.req_write = 4'b0000;
    bus.pready = 1'b1;
    bus.prdata = 32'h1111_2222;
    bus.req = 4'b1111;
    @(negedge pclk);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << k;
      checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL t2_grant%0d got %0h exp %0h", k, bus.grant, exp_g); end
      checks++; if (bus.paddr !== 32'h100 + 32'(k*4)) begin errors++; $display("FAIL t2_paddr%0d got %0h exp %0h", k, bus.paddr, 32'h100 + 32'(k*4)); end
      @(negedge pclk);
      @(negedge pclk);
      checks++; if (bus.done !== exp_g) begin errors++; $display("FAIL t2_done%0d got %0h exp %0h", k, bus.done, exp_g); end
      bus.req[k] = 1'b0;
      if (k == 3) bus.req[0] = 1'b1;
      @(negedge pclk);
    end
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL t2_wrap_grant got %0h exp 1", bus.grant); end
    @(negedge pclk);
    @(negedge pclk);
    checks++; if (bus.done !== 4'b0001) begin errors++; $display("FAIL t2_wrap_done got %0h exp 1", bus.done); end
    bus.req = 4'b0000;
    @(negedge pclk);
  endtask

  task automatic test_write_wait_err();
    bus.req_addr [2*32 +: 32] = 32'h2000_0040;
    bus.req_wdata[2*32 +: 32] = 32'hDEAD_BEEF;
    bus.req_strb [2*4 +: 4]   = 4'b0101;
    bus.req_prot [2*3 +: 3]   = 3'b010;
    bus.req_write[2] = 1'b1;
    bus.pready = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata = 32'h1234_5678;
    bus.req = 4'b0100;
    @(negedge pclk);
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL t3_grant got %0h exp 4", bus.grant); end
    checks++; if (bus.pwrite !== 1'b1)   begin errors++; $display("FAIL t3_pwrite got %0h exp 1", bus.pwrite); end
    checks++; if (bus.pprot !== 3'b010)  begin errors++; $display("FAIL t3_pprot got %0h exp 2", bus.pprot); end
    for (int a = 1; a <= 4; a++) begin
      @(negedge pclk);
      if (a == 2) bus.req_addr[1*32 +: 32] = 32'hFFFF_FFFF;
      checks++; if (bus.penable !== 1'b1) begin errors++; $display("FAIL t3_penable%0d got %0h exp 1", a, bus.penable); end
      checks++; if (bus.paddr !== 32'h2000_0040 || bus.pwdata !== 32'hDEAD_BEEF || bus.pstrb !== 4'b0101)
        begin errors++; $display("FAIL t3_stable%0d got %0h/%0h/%0h exp 20000040/deadbeef/5", a, bus.paddr, bus.pwdata, bus.pstrb); end
      checks++; if (bus.done !== 4'b0000 || bus.grant !== 4'b0100)
        begin errors++; $display("FAIL t3_hold%0d got done %0h grant %0h exp 0/4", a, bus.done, bus.grant); end
      if (a == 4) begin bus.pready = 1'b1; bus.pslverr = 1'b1; end
    end
    @(negedge pclk);
    checks++; if (bus.done !== 4'b0100)  begin errors++; $display("FAIL t3_done got %0h exp 4", bus.done); end
    checks++; if (bus.rsp_err !== 1'b1)  begin errors++; $display("FAIL t3_err got %0h exp 1", bus.rsp_err); end
    checks++; if (bus.rsp_rdata !== '0)  begin errors++; $display("FAIL t3_rdata got %0h exp 0", bus.rsp_rdata); end
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.req = 4'b0000;
    @(negedge pclk);
    checks++; if (bus.rsp_err !== 1'b0)  begin errors++; $display("FAIL t3_err_clear got %0h exp 0", bus.rsp_err); end
  endtask

  task automatic test_reset_mid();
    bus.req_write = 4'b0000;
    bus.req_addr[1*32 +: 32] = 32'h0000_0111;
    bus.req_addr[3*32 +: 32] = 32'h0000_0333;
    bus.pready = 1'b0;
    bus.req = 4'b1010;
    @(negedge pclk);
    checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL t4_grant_pre got %0h exp 8", bus.grant); end
    @(negedge pclk);
    checks++; if (bus.penable !== 1'b1)  begin errors++; $display("FAIL t4_access got %0h exp 1", bus.penable); end
    #2 presetn = 1'b0;
    #1;
    checks++; if (bus.psel !== 1'b0 || bus.penable !== 1'b0)
      begin errors++; $display("FAIL t4_rst_bus got %0h/%0h exp 0/0", bus.psel, bus.penable); end
    checks++; if (bus.grant !== 4'b0000 || bus.done !== 4'b0000)
      begin errors++; $display("FAIL t4_rst_grant got %0h/%0h exp 0/0", bus.grant, bus.done); end
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL t4_grant_post got %0h exp 2", bus.grant); end
    checks++; if (bus.paddr !== 32'h111) begin errors++; $display("FAIL t4_paddr got %0h exp 111", bus.paddr); end
    bus.pready = 1'b1;
    bus.prdata = 32'h0BAD_F00D;
    @(negedge pclk);
    @(negedge pclk);
    checks++; if (bus.done !== 4'b0010)  begin errors++; $display("FAIL t4_done got %0h exp 2", bus.done); end
    checks++; if (bus.rsp_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL t4_rdata got %0h exp badf00d", bus.rsp_rdata); end
    bus.req = 4'b0000;
    bus.pready = 1'b0;
    @(negedge pclk);
  endtask

  task automatic test_timeout();
    int         seen_at;
    logic [3:0] d;
    logic       e;
    logic [31:0] r;
    seen_at = 0; d = '0; e = 1'b0; r = '0;
    bus.req_write[0] = 1'b0;
    bus.pready = 1'b0;
    bus.prdata = 32'hCAFE_0000;
    bus.req = 4'b0001;
    @(negedge pclk);
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL t5_grant got %0h exp 1", bus.grant); end
    for (int c = 1; c <= 100; c++) begin
      @(negedge pclk);
      if (bus.done !== 4'b0000) begin
        seen_at = c; d = bus.done; e = bus.rsp_err; r = bus.rsp_rdata;
        break;
      end
    end
`ifdef APB_ARB_TIMEOUT_EN
    checks++; if (seen_at !== 17)   begin errors++; $display("FAIL t5_tmo_cycle got %0d exp 17", seen_at); end
    checks++; if (d !== 4'b0001)    begin errors++; $display("FAIL t5_tmo_done got %0h exp 1", d); end
    checks++; if (e !== 1'b1)       begin errors++; $display("FAIL t5_tmo_err got %0h exp 1", e); end
    checks++; if (r !== 32'h0)      begin errors++; $display("FAIL t5_tmo_rdata got %0h exp 0", r); end
    bus.req = 4'b0000;
    @(negedge pclk);
`else
    checks++; if (seen_at !== 0)    begin errors++; $display("FAIL t5_no_tmo got done at %0d exp none", seen_at); end
    checks++; if (bus.psel !== 1'b1 || bus.penable !== 1'b1)
      begin errors++; $display("FAIL t5_still_access got %0h/%0h exp 1/1", bus.psel, bus.penable); end
    bus.pready = 1'b1;
    @(negedge pclk);
    checks++; if (bus.done !== 4'b0001 || bus.rsp_rdata !== 32'hCAFE_0000)
      begin errors++; $display("FAIL t5_late_done got %0h/%0h exp 1/cafe0000", bus.done, bus.rsp_rdata); end
    bus.req = 4'b0000;
    bus.pready = 1'b0;
    @(negedge pclk);
`endif
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_wait_err();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
